// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
//   Bundles the EX-stage operand-forwarding and HI/LO multiply/divide signals.
//   master : pipeline side (drives selects, operands, op requests)
//   slave  : ex_muldiv_unit side (drives forwarded operands, HI/LO, busy/stall)
//   Signals:
//     ForwardA_EX/ForwardB_EX [1:0]  forwarding selects for rs/rt
//     id_ex_rs_data/id_ex_rt_data    register-file operands from ID/EX
//     ex_mem_alu_out                 forward source 2'b10
//     mem_wb_write_data              forward source 2'b01
//     md_start, md_op[2:0], md_read  HI/LO op request / mfhi-mflo present
//     operand_a/operand_b            resolved operands
//     hi, lo, md_busy, md_stall      HI/LO state and divide status
interface ex_muldiv_unit_if;
    logic [1:0]  ForwardA_EX;
    logic [1:0]  ForwardB_EX;
    logic [31:0] id_ex_rs_data;
    logic [31:0] id_ex_rt_data;
    logic [31:0] ex_mem_alu_out;
    logic [31:0] mem_wb_write_data;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_read;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_busy;
    logic        md_stall;

    modport master (
        output ForwardA_EX, ForwardB_EX, id_ex_rs_data, id_ex_rt_data,
               ex_mem_alu_out, mem_wb_write_data, md_start, md_op, md_read,
        input  operand_a, operand_b, hi, lo, md_busy, md_stall
    );

    modport slave (
        input  ForwardA_EX, ForwardB_EX, id_ex_rs_data, id_ex_rt_data,
               ex_mem_alu_out, mem_wb_write_data, md_start, md_op, md_read,
        output operand_a, operand_b, hi, lo, md_busy, md_stall
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   EX-stage operand-forwarding mux plus a private HI/LO register pair that
//   executes mult/multu/div/divu/mthi/mtlo. Multiplies and moves complete in
//   the issue cycle; divides run a 32-step restoring divider and stall the
//   front of the pipeline while in flight.
//   Ports:
//     clk    pipeline clock, rising edge
//     reset  synchronous active-high, clears all state
//     bus    ex_muldiv_unit_if.slave (forwarding inputs, op request,
//            forwarded operands, hi/lo, md_busy, md_stall)
//   Build option:
//     MULDIV_DIV_EN  when defined, the iterative divider is built; otherwise
//                    div/divu are no-ops and md_busy/md_stall are tied 0.
module ex_muldiv_unit (
    input  logic               clk,
    input  logic               reset,
    ex_muldiv_unit_if.slave    bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [31:0] opa, opb;
    logic [31:0] hi_q, lo_q;
    logic        busy_q;
    logic        accept;
    logic [63:0] prod_s, prod_u;

    // Forward mux; 2'b11 is reserved and falls back to the register file.
    always_comb begin
        opa = bus.id_ex_rs_data;
        case (bus.ForwardA_EX)
            2'b10:   opa = bus.ex_mem_alu_out;
            2'b01:   opa = bus.mem_wb_write_data;
            default: opa = bus.id_ex_rs_data;
        endcase
        opb = bus.id_ex_rt_data;
        case (bus.ForwardB_EX)
            2'b10:   opb = bus.ex_mem_alu_out;
            2'b01:   opb = bus.mem_wb_write_data;
            default: opb = bus.id_ex_rt_data;
        endcase
    end

    // Operands widened to 64 bits so the low 64 bits of the product are exact.
    assign prod_s = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
    assign prod_u = {32'd0, opa} * {32'd0, opb};

    // A new HI/LO op is only taken when no divide is in flight; a blocked
    // instruction is re-presented by the pipeline once the stall drops.
    assign accept = bus.md_start & ~busy_q;

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;       // holds the dividend, shifted out as quotient bits enter
    logic [31:0] dvsr;
    logic [31:0] dvnd_raw;  // original dividend, needed for the divide-by-zero result
    logic        q_neg, r_neg;
    logic        is_signed;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [31:0] q_fix, r_fix;

    assign is_signed = (bus.md_op == OP_DIV);
    assign shifted   = {rem[31:0], quo[31]};
    // One extra bit so the borrow is visible even when shifted >= 2^32.
    assign diff      = {1'b0, shifted} - {2'b00, dvsr};
    assign q_fix     = q_neg ? (~quo + 32'd1) : quo;
    assign r_fix     = r_neg ? (~rem[31:0] + 32'd1) : rem[31:0];
`else
    assign busy_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
`ifdef MULDIV_DIV_EN
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            cnt      <= 6'd0;
            rem      <= 33'd0;
            quo      <= 32'd0;
            dvsr     <= 32'd0;
            dvnd_raw <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                case (bus.md_op)
                    OP_MULT:  {hi_q, lo_q} <= prod_s;
                    OP_MULTU: {hi_q, lo_q} <= prod_u;
                    OP_MTHI:  hi_q <= opa;
                    OP_MTLO:  lo_q <= opa;
`ifdef MULDIV_DIV_EN
                    OP_DIV, OP_DIVU: begin
                        state    <= S_DIV;
                        busy_q   <= 1'b1;
                        cnt      <= 6'd0;
                        rem      <= 33'd0;
                        quo      <= (is_signed && opa[31]) ? (~opa + 32'd1) : opa;
                        dvsr     <= (is_signed && opb[31]) ? (~opb + 32'd1) : opb;
                        dvnd_raw <= opa;
                        q_neg    <= is_signed & (opa[31] ^ opb[31]);
                        r_neg    <= is_signed & opa[31];
                    end
`endif
                    default: ;
                endcase
            end
`ifdef MULDIV_DIV_EN
            case (state)
                S_DIV: begin
                    if (!diff[33]) begin
                        rem <= diff[32:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31)
                        state <= S_DONE;
                end
                S_DONE: begin
                    // A zero divisor makes every step "succeed"; override the
                    // natural result with the architected one.
                    if (dvsr == 32'd0) begin
                        lo_q <= 32'hFFFF_FFFF;
                        hi_q <= dvnd_raw;
                    end else begin
                        lo_q <= q_fix;
                        hi_q <= r_fix;
                    end
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: ;
            endcase
`endif
        end
    end

    assign bus.operand_a = opa;
    assign bus.operand_b = opb;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.md_busy   = busy_q;
    assign bus.md_stall  = busy_q & (bus.md_start | bus.md_read);
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Execute-stage operand-forwarding mux and HI/LO multiply/divide unit. It consumes the two 2-bit EX forwarding selects produced by the EX forwarding control, resolves the final rs/rt operands for the ALU, and executes MIPS mult/multu/div/divu/mthi/mtlo against a private HI/LO register pair. It sits in EX, between the ID/EX pipeline register and the EX/MEM register. It stalls the front of the pipeline while an iterative divide is in flight.

## Interface
- No parameters; datapath is fixed at 32 bits.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- ForwardA_EX  in  2  rs operand select.
- ForwardB_EX  in  2  rt operand select.
- id_ex_rs_data  in  32  register-file rs value from ID/EX.
- id_ex_rt_data  in  32  register-file rt value from ID/EX.
- ex_mem_alu_out  in  32  EX/MEM result (forward source 2'b10).
- mem_wb_write_data  in  32  WB write-back value (forward source 2'b01).
- md_start  in  1  EX holds a valid HI/LO-writing instruction; upstream deasserts it for bubbles and flushes.
- md_op  in  3  3'd1 mult, 3'd2 multu, 3'd3 div, 3'd4 divu, 3'd5 mthi, 3'd6 mtlo; others are no-op.
- md_read  in  1  EX holds mfhi/mflo.
- operand_a  out  32  forwarded rs value (combinational).
- operand_b  out  32  forwarded rt value (combinational).
- hi  out  32  HI register; reset 0.
- lo  out  32  LO register; reset 0.
- md_busy  out  1  divide in flight; reset 0.
- md_stall  out  1  hold IF/ID/EX and bubble EX/MEM; reset 0.

## Operation
- Forward mux, per operand: 2'b00 → id_ex data; 2'b10 → ex_mem_alu_out; 2'b01 → mem_wb_write_data; 2'b11 → id_ex data (reserved).
- All HI/LO operations use operand_a and operand_b.
- md_stall = md_busy & (md_start | md_read).
- When md_busy is high, md_start is not accepted. The pipeline re-presents the instruction once the stall releases.
- mult / multu: HI:LO = 64-bit signed or unsigned product. Written on the issue edge. md_busy is not asserted.
- mthi / mtlo: HI or LO = operand_a on the issue edge.
- div / divu FSM:
  - IDLE → DIV on accepted start. The FSM latches absolute-value (div) or raw (divu) operands and the result signs, and clears a 6-bit count.
  - DIV performs one restoring shift-subtract step per cycle. After 32 steps it moves to DONE.
  - DONE applies sign fixup, writes LO = quotient and HI = remainder, then returns to IDLE.
- Signed rules: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
- 0x80000000 / -1 (signed): LO = 0x80000000, HI = 0.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend. This applies to both div and divu, and the full latency is still used.
- md_busy = (state != IDLE).
- Reset in any state: FSM goes to IDLE, count is cleared, HI/LO = 0, and any in-flight divide is discarded.

## Timing
- Operand mux: zero latency.
- mult/multu/mthi/mtlo issued in cycle T: HI/LO are updated at the end of T, and mfhi/mflo in T+1 read the new value.
- div issued in cycle T:
  - md_busy is high for T+1..T+33.
  - HI/LO are written at the end of T+33.
  - mfhi/mflo or a new HI/LO op in T+1..T+33 are stalled.
  - The first non-stalled read is in T+34 and returns the new value.
- Back-to-back mult after div: the mult stalls until T+34 and writes at the end of T+34.
- md_read in the issue cycle of a mult observes the old HI/LO. The write is not bypassed.

## Configuration
- MULDIV_DIV_EN defined: the divide FSM, md_busy and md_stall behave as above.
- MULDIV_DIV_EN undefined:
  - The divider is not synthesized.
  - div/divu are no-ops: HI/LO are unchanged.
  - md_busy and md_stall are tied 0.
  - Forwarding, mult/multu and mthi/mtlo are unchanged.

## Test plan
- Forwarding: rs_data=1, ex_mem=2, wb=3. ForwardA=10 → operand_a=2; 01 → 3; 00 → 1; 11 → 1. Repeat for B.
- multu 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE. mult −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Both visible next cycle, no stall.
- div −7/2 issued at T:
  - md_busy high T+1..T+33.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF at T+34.
  - md_read held from T+1 gives md_stall=1 until T+34.
- divu 10/0 → LO=0xFFFFFFFF, HI=10. div 0x80000000/−1 → LO=0x80000000, HI=0.
- Reset asserted at T+10 of a divide → next cycle md_busy=0, HI=LO=0. A following mthi 0x1234 gives HI=0x1234.
- Build without MULDIV_DIV_EN: divu 10/3 leaves HI/LO unchanged and md_stall stays 0. The mult test still passes.
